vu_cmd_fetch: RTL and testbench

VU_CMD_FETCH -- requirements
Module: vu_cmd_fetch

---
 rtl/vu_cmd_fetch_pkg.sv | 72 +++++++
 rtl/vu_fifo.sv | 54 +++++
 rtl/vu_cmd_fetch.sv | 148 ++++++++++++++
 tb/tb_vu_cmd_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vu_cmd_fetch_pkg.sv
// Shared opcode header for the vector command fetch unit: command encodings,
// immediate-count classification and fetch FSM state encodings.
package vu_cmd_fetch_pkg;

    localparam int XCMD_CMD_SZ = 8;

    localparam logic [XCMD_CMD_SZ-1:0] CMD_FENCE_L_V  = 8'h00;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_FENCE_G_V  = 8'h01;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_FENCE_L_CV = 8'h02;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_FENCE_G_CV = 8'h03;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VMVV       = 8'h04;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VMST       = 8'h05;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VMTS       = 8'h06;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VFMVV      = 8'h07;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VFMST      = 8'h08;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VFMTS      = 8'h09;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_LDWB       = 8'h0A;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_STAC       = 8'h0B;

    localparam logic [XCMD_CMD_SZ-1:0] CMD_VVCFGIVL   = 8'h10;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSETVL     = 8'h11;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VF         = 8'h12;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VMSV       = 8'h13;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VFMSV      = 8'h14;

    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLD        = 8'h20;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLW        = 8'h21;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLH        = 8'h22;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLB        = 8'h23;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSD        = 8'h24;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSW        = 8'h25;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSH        = 8'h26;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSB        = 8'h27;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLXD       = 8'h28;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLXW       = 8'h29;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSXD       = 8'h2A;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSXW       = 8'h2B;

    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLSTD      = 8'h30;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VLSTW      = 8'h31;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSSTD      = 8'h32;
    localparam logic [XCMD_CMD_SZ-1:0] CMD_VSSTW      = 8'h33;

    // Encoding 3 is never a real immediate count; it marks an undefined opcode.
    localparam logic [1:0] NIMM_UNDEF = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD1 = 2'd1,
        ST_OUT   = 2'd2
    } fetch_state_e;

    function automatic logic [1:0] cmd_nimm(input logic [XCMD_CMD_SZ-1:0] cmd);
        logic [1:0] n;
        case (cmd)
            CMD_FENCE_L_V, CMD_FENCE_G_V, CMD_FENCE_L_CV, CMD_FENCE_G_CV,
            CMD_VMVV, CMD_VMST, CMD_VMTS, CMD_VFMVV, CMD_VFMST, CMD_VFMTS,
            CMD_LDWB, CMD_STAC:
                n = 2'd0;
            CMD_VVCFGIVL, CMD_VSETVL, CMD_VF, CMD_VMSV, CMD_VFMSV,
            CMD_VLD, CMD_VLW, CMD_VLH, CMD_VLB, CMD_VSD, CMD_VSW, CMD_VSH, CMD_VSB,
            CMD_VLXD, CMD_VLXW, CMD_VSXD, CMD_VSXW:
                n = 2'd1;
            CMD_VLSTD, CMD_VLSTW, CMD_VSSTD, CMD_VSSTW:
                n = 2'd2;
            default:
                n = NIMM_UNDEF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vu_fifo.sv
// Circular-buffer FIFO with val/rdy enqueue, head plus second-entry peek,
// and the ability to retire one or two entries in a cycle.
module vu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_val,
    input  logic             deq_rdy,
    input  logic             deq_two,
    output logic [WIDTH-1:0] deq_bits,
    output logic [WIDTH-1:0] deq_next,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             enq_fire;
    logic [1:0]       pop_n;

    assign enq_rdy  = reset_n && (count != CW'(DEPTH));
    assign enq_fire = enq_val && enq_rdy;
    assign deq_val  = (count != '0);
    assign deq_bits = mem[rptr];
    assign deq_next = mem[rptr + AW'(1)];
    // deq_two is only honoured by callers that have checked count >= 2.
    assign pop_n    = !(deq_rdy && deq_val) ? 2'd0 : (deq_two ? 2'd2 : 2'd1);

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wptr] <= enq_bits;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(enq_fire);
            rptr  <= rptr + AW'(pop_n);
            count <= count + CW'(enq_fire) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/vu_cmd_fetch.sv
// Vector command fetch: pairs queued commands with their immediates and
// presents them as one registered issue bundle to the decode stage.
module vu_cmd_fetch
    import vu_cmd_fetch_pkg::*;
#(
    parameter int CMDQ_DEPTH = 8,
    parameter int IMMQ_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmdq_enq_val,
    output logic                   cmdq_enq_rdy,
    input  logic [XCMD_CMD_SZ-1:0] cmdq_enq_bits,
    input  logic                   immq_enq_val,
    output logic                   immq_enq_rdy,
    input  logic [63:0]            immq_enq_bits,
    output logic                   issue_val,
    input  logic                   issue_rdy,
    output logic [XCMD_CMD_SZ-1:0] issue_cmd,
    output logic [63:0]            issue_imm1,
    output logic [63:0]            issue_imm2,
    output logic                   err_undef
);

    localparam int CCW = $clog2(CMDQ_DEPTH) + 1;
    localparam int ICW = $clog2(IMMQ_DEPTH) + 1;

    fetch_state_e             state, state_n;
    logic                     head_val, imm_val;
    logic [XCMD_CMD_SZ-1:0]   head_cmd;
    logic [XCMD_CMD_SZ-1:0]   cmdq_unused_next;
    logic [CCW-1:0]           cmdq_unused_count;
    logic [63:0]              imm_head, imm_next;
    logic [ICW-1:0]           imm_count;
    logic [1:0]               head_nimm;
    logic                     issuable, take;
    logic                     cmd_pop, imm_pop, imm_two;
    logic                     out_load, hold_load, err_set;
    logic [63:0]              out_imm1_n, out_imm2_n;
    logic [63:0]              imm1_hold;
    logic [XCMD_CMD_SZ-1:0]   out_cmd;
    logic [63:0]              out_imm1, out_imm2;

    vu_fifo #(.WIDTH(XCMD_CMD_SZ), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk(clk), .reset_n(reset_n),
        .enq_val(cmdq_enq_val), .enq_rdy(cmdq_enq_rdy), .enq_bits(cmdq_enq_bits),
        .deq_val(head_val), .deq_rdy(cmd_pop), .deq_two(1'b0),
        .deq_bits(head_cmd), .deq_next(cmdq_unused_next), .count(cmdq_unused_count)
    );

    vu_fifo #(.WIDTH(64), .DEPTH(IMMQ_DEPTH)) u_immq (
        .clk(clk), .reset_n(reset_n),
        .enq_val(immq_enq_val), .enq_rdy(immq_enq_rdy), .enq_bits(immq_enq_bits),
        .deq_val(imm_val), .deq_rdy(imm_pop), .deq_two(imm_two),
        .deq_bits(imm_head), .deq_next(imm_next), .count(imm_count)
    );

    assign head_nimm = cmd_nimm(head_cmd);
    assign issuable  = head_val && (head_nimm != NIMM_UNDEF) && (imm_count >= ICW'(head_nimm));

    // Next-state and pop control; take means the head command and all of its
    // immediates leave the queues together this cycle.
    always_comb begin
        state_n    = state;
        take       = 1'b0;
        cmd_pop    = 1'b0;
        imm_pop    = 1'b0;
        imm_two    = 1'b0;
        out_load   = 1'b0;
        hold_load  = 1'b0;
        err_set    = 1'b0;
        out_imm1_n = (head_nimm != 2'd0) ? imm_head : 64'd0;
        out_imm2_n = (head_nimm == 2'd2) ? imm_next : 64'd0;
        case (state)
            ST_IDLE: begin
                if (head_val && head_nimm == NIMM_UNDEF) begin
                    cmd_pop = 1'b1;
                    err_set = 1'b1;
                end else if (issuable) begin
                    take = 1'b1;
                end else if (head_val && head_nimm == 2'd2 && imm_count == ICW'(1)) begin
                    imm_pop   = 1'b1;
                    hold_load = 1'b1;
                    state_n   = ST_HOLD1;
                end
            end
            ST_HOLD1: begin
                if (imm_val) begin
                    cmd_pop    = 1'b1;
                    imm_pop    = 1'b1;
                    out_load   = 1'b1;
                    out_imm1_n = imm1_hold;
                    out_imm2_n = imm_head;
                    state_n    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (issue_rdy) begin
                    if (issuable) begin
                        take = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (take) begin
            cmd_pop  = 1'b1;
            imm_pop  = (head_nimm != 2'd0);
            imm_two  = (head_nimm == 2'd2);
            out_load = 1'b1;
            state_n  = ST_OUT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            imm1_hold <= '0;
            out_cmd   <= '0;
            out_imm1  <= '0;
            out_imm2  <= '0;
            err_undef <= 1'b0;
        end else begin
            state <= state_n;
            if (hold_load) begin
                imm1_hold <= imm_head;
            end
            if (out_load) begin
                out_cmd  <= head_cmd;
                out_imm1 <= out_imm1_n;
                out_imm2 <= out_imm2_n;
            end
            if (err_set) begin
                err_undef <= 1'b1;
            end
        end
    end

    assign issue_val  = (state == ST_OUT);
    assign issue_cmd  = out_cmd;
    assign issue_imm1 = out_imm1;
    assign issue_imm2 = out_imm2;

endmodule

// File: tb/tb_vu_cmd_fetch.sv
// Directed and scoreboarded bench for vu_cmd_fetch.
module tb_vu_cmd_fetch;
    import vu_cmd_fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmdq_enq_val;
    logic        cmdq_enq_rdy;
    logic [7:0]  cmdq_enq_bits;
    logic        immq_enq_val;
    logic        immq_enq_rdy;
    logic [63:0] immq_enq_bits;
    logic        issue_val;
    logic        issue_rdy;
    logic [7:0]  issue_cmd;
    logic [63:0] issue_imm1;
    logic [63:0] issue_imm2;
    logic        err_undef;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] i1;
        logic [63:0] i2;
    } exp_t;

    exp_t sb[$];
    logic drv_done;

    vu_cmd_fetch #(.CMDQ_DEPTH(8), .IMMQ_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmdq_enq_val(cmdq_enq_val), .cmdq_enq_rdy(cmdq_enq_rdy), .cmdq_enq_bits(cmdq_enq_bits),
        .immq_enq_val(immq_enq_val), .immq_enq_rdy(immq_enq_rdy), .immq_enq_bits(immq_enq_bits),
        .issue_val(issue_val), .issue_rdy(issue_rdy),
        .issue_cmd(issue_cmd), .issue_imm1(issue_imm1), .issue_imm2(issue_imm2),
        .err_undef(err_undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic enq_cmd(input logic [7:0] c);
        int n = 0;
        cmdq_enq_val  = 1'b1;
        cmdq_enq_bits = c;
        while (!cmdq_enq_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n == 200) begin
            vectors++; miscompares++;
            $display("[TB] FAIL enq_cmd_timeout: got rdy=0 want rdy=1 for cmd %h", c);
        end
        @(posedge clk); #1;
        cmdq_enq_val = 1'b0;
    endtask

    task automatic enq_imm(input logic [63:0] v);
        int n = 0;
        immq_enq_val  = 1'b1;
        immq_enq_bits = v;
        while (!immq_enq_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n == 200) begin
            vectors++; miscompares++;
            $display("[TB] FAIL enq_imm_timeout: got rdy=0 want rdy=1 for imm %h", v);
        end
        @(posedge clk); #1;
        immq_enq_val = 1'b0;
    endtask

    task automatic retire;
        issue_rdy = 1'b1;
        @(posedge clk); #1;
        issue_rdy = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_issue_val: got %b want 0", issue_val); end
        vectors++; if (cmdq_enq_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmdq_rdy: got %b want 0", cmdq_enq_rdy); end
        vectors++; if (immq_enq_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_immq_rdy: got %b want 0", immq_enq_rdy); end
        vectors++; if (err_undef !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", err_undef); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (cmdq_enq_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_cmdq_rdy: got %b want 1", cmdq_enq_rdy); end
        vectors++; if (immq_enq_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_immq_rdy: got %b want 1", immq_enq_rdy); end
    endtask

    task automatic test_single_imm;
        issue_rdy = 1'b0;
        enq_cmd(CMD_VSETVL);
        enq_imm(64'h20);
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL vsetvl_early: got %b want 0", issue_val); end
        @(negedge clk);
        vectors++; if (issue_val !== 1'b1) begin miscompares++; $display("[TB] FAIL vsetvl_latency: got %b want 1", issue_val); end
        vectors++; if (issue_cmd !== CMD_VSETVL) begin miscompares++; $display("[TB] FAIL vsetvl_cmd: got %h want %h", issue_cmd, CMD_VSETVL); end
        vectors++; if (issue_imm1 !== 64'h20) begin miscompares++; $display("[TB] FAIL vsetvl_imm1: got %h want 20", issue_imm1); end
        vectors++; if (issue_imm2 !== 64'h0) begin miscompares++; $display("[TB] FAIL vsetvl_imm2: got %h want 0", issue_imm2); end
        retire();
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL vsetvl_retire: got %b want 0", issue_val); end
    endtask

    task automatic test_hold1;
        enq_cmd(CMD_VLSTW);
        enq_imm(64'h1000);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (dut.state !== ST_HOLD1 || issue_val !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold1_state: got state=%0d val=%b want state=%0d val=0", dut.state, issue_val, ST_HOLD1);
            end
        end
        enq_imm(64'h8);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (issue_val !== 1'b1) begin miscompares++; $display("[TB] FAIL vlstw_val: got %b want 1", issue_val); end
        vectors++; if (issue_cmd !== CMD_VLSTW) begin miscompares++; $display("[TB] FAIL vlstw_cmd: got %h want %h", issue_cmd, CMD_VLSTW); end
        vectors++; if (issue_imm1 !== 64'h1000) begin miscompares++; $display("[TB] FAIL vlstw_imm1: got %h want 1000", issue_imm1); end
        vectors++; if (issue_imm2 !== 64'h8) begin miscompares++; $display("[TB] FAIL vlstw_imm2: got %h want 8", issue_imm2); end
        retire();
    endtask

    task automatic test_back_to_back;
        logic [7:0] list [9];
        list = '{CMD_FENCE_L_V, CMD_FENCE_G_V, CMD_FENCE_L_CV, CMD_FENCE_G_CV,
                 CMD_VMVV, CMD_VMST, CMD_VMTS, CMD_LDWB, CMD_STAC};
        issue_rdy = 1'b0;
        // The first command moves into the output register, so nine fill the unit.
        for (int i = 0; i < 9; i++) begin
            enq_cmd(list[i]);
        end
        @(negedge clk);
        vectors++; if (cmdq_enq_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rdy: got %b want 0", cmdq_enq_rdy); end
        vectors++; if (issue_val !== 1'b1 || issue_cmd !== list[0]) begin miscompares++; $display("[TB] FAIL b2b_0: got val=%b cmd=%h want val=1 cmd=%h", issue_val, issue_cmd, list[0]); end
        issue_rdy = 1'b1;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            vectors++;
            if (issue_val !== 1'b1 || issue_cmd !== list[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_%0d: got val=%b cmd=%h want val=1 cmd=%h", i, issue_val, issue_cmd, list[i]);
            end
        end
        @(negedge clk);
        issue_rdy = 1'b0;
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %b want 0", issue_val); end
    endtask

    task automatic test_undefined;
        int n = 0;
        issue_rdy = 1'b0;
        enq_cmd(8'hFF);
        enq_cmd(CMD_VF);
        enq_imm(64'h40);
        while (!issue_val && n < 20) begin
            @(negedge clk); n++;
        end
        vectors++; if (err_undef !== 1'b1) begin miscompares++; $display("[TB] FAIL undef_err: got %b want 1", err_undef); end
        vectors++; if (issue_val !== 1'b1) begin miscompares++; $display("[TB] FAIL undef_vf_timeout: got val=%b want 1", issue_val); end
        vectors++; if (issue_cmd !== CMD_VF) begin miscompares++; $display("[TB] FAIL undef_vf_cmd: got %h want %h", issue_cmd, CMD_VF); end
        vectors++; if (issue_imm1 !== 64'h40) begin miscompares++; $display("[TB] FAIL undef_vf_imm1: got %h want 40", issue_imm1); end
        vectors++; if (issue_imm2 !== 64'h0) begin miscompares++; $display("[TB] FAIL undef_vf_imm2: got %h want 0", issue_imm2); end
        retire();
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL undef_extra_issue: got %b want 0", issue_val); end
        vectors++; if (dut.u_immq.count !== '0) begin miscompares++; $display("[TB] FAIL undef_immq_count: got %0d want 0", dut.u_immq.count); end
    endtask

    task automatic test_reset_midop;
        int n = 0;
        issue_rdy = 1'b0;
        enq_cmd(CMD_VSETVL);
        enq_cmd(CMD_VLW);
        enq_cmd(CMD_VLSTW);
        enq_imm(64'h1);
        enq_imm(64'h2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_val: got %b want 0", issue_val); end
        vectors++; if (dut.u_cmdq.count !== '0) begin miscompares++; $display("[TB] FAIL midrst_cmdq_count: got %0d want 0", dut.u_cmdq.count); end
        vectors++; if (dut.u_immq.count !== '0) begin miscompares++; $display("[TB] FAIL midrst_immq_count: got %0d want 0", dut.u_immq.count); end
        vectors++; if (err_undef !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_err: got %b want 0", err_undef); end
        vectors++; if (cmdq_enq_rdy !== 1'b0 || immq_enq_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rdy: got %b%b want 00", cmdq_enq_rdy, immq_enq_rdy); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_val: got %b want 0", issue_val); end
        enq_cmd(CMD_VSETVL);
        enq_imm(64'h5);
        while (!issue_val && n < 20) begin
            @(negedge clk); n++;
        end
        vectors++; if (issue_val !== 1'b1) begin miscompares++; $display("[TB] FAIL postrst_timeout: got val=%b want 1", issue_val); end
        vectors++; if (issue_cmd !== CMD_VSETVL) begin miscompares++; $display("[TB] FAIL postrst_cmd: got %h want %h", issue_cmd, CMD_VSETVL); end
        vectors++; if (issue_imm1 !== 64'h5) begin miscompares++; $display("[TB] FAIL postrst_imm1: got %h want 5", issue_imm1); end
        vectors++; if (issue_imm2 !== 64'h0) begin miscompares++; $display("[TB] FAIL postrst_imm2: got %h want 0", issue_imm2); end
        retire();
    endtask

    task automatic test_random;
        logic [7:0] pool_cmd [12];
        int         pool_nimm [12];
        pool_cmd  = '{CMD_FENCE_L_V, CMD_VMVV, CMD_LDWB, CMD_STAC, CMD_VSETVL, CMD_VF,
                      CMD_VLW, CMD_VSXD, CMD_VLSTD, CMD_VSSTW, CMD_VFMSV, CMD_VFMTS};
        pool_nimm = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 1, 0};
        drv_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    int    p;
                    exp_t  e;
                    logic [63:0] v [2];
                    p    = $urandom_range(0, 11);
                    v[0] = {$urandom, $urandom};
                    v[1] = {$urandom, $urandom};
                    e.cmd = pool_cmd[p];
                    e.i1  = (pool_nimm[p] >= 1) ? v[0] : 64'd0;
                    e.i2  = (pool_nimm[p] == 2) ? v[1] : 64'd0;
                    enq_cmd(pool_cmd[p]);
                    sb.push_back(e);
                    for (int j = 0; j < pool_nimm[p]; j++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                        enq_imm(v[j]);
                    end
                end
                drv_done = 1'b1;
            end
            begin
                int   cycles = 0;
                logic prev_stall = 1'b0;
                exp_t prev;
                exp_t got;
                while ((!drv_done || sb.size() != 0) && cycles < 20000) begin
                    @(posedge clk); #1;
                    issue_rdy = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cycles++;
                    got.cmd = issue_cmd; got.i1 = issue_imm1; got.i2 = issue_imm2;
                    if (prev_stall) begin
                        vectors++;
                        if (!issue_val || got.cmd !== prev.cmd || got.i1 !== prev.i1 || got.i2 !== prev.i2) begin
                            miscompares++;
                            $display("[TB] FAIL stall_stable: got val=%b %h/%h/%h want val=1 %h/%h/%h",
                                     issue_val, got.cmd, got.i1, got.i2, prev.cmd, prev.i1, prev.i2);
                        end
                    end
                    if (issue_val && issue_rdy) begin
                        vectors++;
                        if (sb.size() == 0) begin
                            miscompares++;
                            $display("[TB] FAIL rand_unexpected: got cmd %h want no issue", got.cmd);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            if (got.cmd !== e.cmd || got.i1 !== e.i1 || got.i2 !== e.i2) begin
                                miscompares++;
                                $display("[TB] FAIL rand_issue: got %h/%h/%h want %h/%h/%h",
                                         got.cmd, got.i1, got.i2, e.cmd, e.i1, e.i2);
                            end
                        end
                    end
                    prev_stall = issue_val && !issue_rdy;
                    prev = got;
                end
                if (cycles >= 20000) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL rand_timeout: got %0d pending want 0", sb.size());
                end
            end
        join
        @(posedge clk); #1;
        issue_rdy = 1'b0;
        @(negedge clk);
        vectors++; if (issue_val !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_leftover: got %b want 0", issue_val); end
    endtask

    initial begin
        reset_n       = 1'b0;
        cmdq_enq_val  = 1'b0;
        cmdq_enq_bits = '0;
        immq_enq_val  = 1'b0;
        immq_enq_bits = '0;
        issue_rdy     = 1'b0;
        drv_done      = 1'b0;
        test_reset();
        test_single_imm();
        test_hold1();
        test_back_to_back();
        test_undefined();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
